// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and a shared FIFO.
// The slave modport is the arbiter; master is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [OWNER_W-1:0]            owner;

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr_en, fifo_wdata, owner
  );

  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr_en, fifo_wdata, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared synchronous FIFO.
// Grants are combinational (zero-cycle); owner and burst count are registered.
// A granted producer may keep the port for up to MAX_BURST consecutive writes;
// a full FIFO stalls everything without breaking the burst.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2,
  localparam int OWNER_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int BCNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BCNT_W-1:0]  BURST_MAX   = BCNT_W'(MAX_BURST);
  localparam logic [OWNER_W-1:0] OWNER_RESET = OWNER_W'(NUM_REQ - 1);

  logic [OWNER_W-1:0]    owner_q;
  logic [BCNT_W-1:0]     burst_cnt;

  logic [OWNER_W-1:0]    win;
  logic                  grant_any;
  logic                  burst_cont;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // Grant decision: continue the current burst if allowed, else rotate from owner+1.
  always_comb begin
    logic                found;
    logic [OWNER_W-1:0]  cand;
    win        = owner_q;
    grant_any  = 1'b0;
    burst_cont = 1'b0;
    found      = 1'b0;
    cand       = '0;
    if (rst_n && !bus.fifo_full) begin
      if ((burst_cnt != '0) && (burst_cnt < BURST_MAX) && bus.req[owner_q]) begin
        win        = owner_q;
        grant_any  = 1'b1;
        burst_cont = 1'b1;
      end else begin
        // Owner itself is the last candidate (k == NUM_REQ wraps back to it).
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = OWNER_W'((int'(owner_q) + k) % NUM_REQ);
          if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        grant_any = found;
      end
    end
  end

  // One-hot grant and the muxed write word; both zero when nobody is granted.
  always_comb begin
    gnt_c   = '0;
    wdata_c = '0;
    if (grant_any) begin
      gnt_c[win] = 1'b1;
      wdata_c    = bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Ownership and burst tracking; a full FIFO freezes both so the burst survives backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWNER_RESET;
      burst_cnt <= '0;
    end else if (!bus.fifo_full) begin
      if (grant_any) begin
        owner_q   <= win;
        burst_cnt <= burst_cont ? (burst_cnt + 1'b1) : BCNT_W'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.fifo_wr_en = grant_any;
  assign bus.fifo_wdata = wdata_c;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a stimulus process predicts each cycle
// from a behavioural round-robin model and queues the expectation; a monitor
// on the falling edge pops and compares, and also checks the safety and
// fairness properties of every cycle.
module tb_fifo_wr_arbiter;
  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int MB   = 2;
  localparam int OW   = $clog2(N);
  localparam int WAIT_LIMIT = (N - 1) * MB + 1;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic [OW-1:0] owner;
    bit            hint_v;
    logic [N-1:0]  hint;
  } exp_t;

  logic clk;
  logic rst_n;
  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] pdata [N];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_owner;
  int   m_burst;
  int   waitc [N];

  // Pack producer words onto the bus.
  always_comb begin
    bus.req_data = '0;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pdata[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: continue a live burst, else the first requester in
  // rotating order owner+1 .. owner (mod N).
  task automatic model_step(input logic [N-1:0] r, input logic full, output int win);
    int i;
    win = -1;
    if (full) return;
    if (m_burst > 0 && m_burst < MB && r[m_owner]) begin
      win = m_owner;
      m_burst++;
      return;
    end
    if (r == '0) begin
      m_burst = 0;
      return;
    end
    for (int k = 1; k <= N; k++) begin
      i = (m_owner + k) % N;
      if (r[i]) begin
        win = i;
        break;
      end
    end
    m_owner = win;
    m_burst = 1;
  endtask

  task automatic model_reset();
    m_owner = N - 1;
    m_burst = 0;
  endtask

  // Called at posedge+1: drive one cycle, queue its expectation, advance to next posedge+1.
  task automatic drive_cycle(input logic [N-1:0] r, input logic full, input bit hv,
                             input logic [N-1:0] h, output int win);
    exp_t e;
    bus.req       = r;
    bus.fifo_full = full;
    e.owner  = OW'(m_owner);
    model_step(r, full, win);
    e.gnt    = (win >= 0) ? (N'(1) << win) : '0;
    e.wr_en  = (win >= 0);
    e.wdata  = (win >= 0) ? pdata[win] : '0;
    e.hint_v = hv;
    e.hint   = h;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req       = '1;
    bus.fifo_full = 1'b0;
    #1;
    check("rst_gnt",   32'(bus.gnt), 32'(0));
    check("rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    check("rst_owner", 32'(bus.owner), 32'(N - 1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pop and compare expected outputs, then the per-cycle properties.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",   32'(bus.gnt), 32'(e.gnt));
        check("wr_en", 32'(bus.fifo_wr_en), 32'(e.wr_en));
        check("wdata", 32'(bus.fifo_wdata), 32'(e.wdata));
        check("owner", 32'(bus.owner), 32'(e.owner));
        if (e.hint_v) check("gnt_directed", 32'(bus.gnt), 32'(e.hint));
      end
      check("gnt_onehot0", 32'($countones(bus.gnt) <= 1), 32'(1));
      check("gnt_implies_req", 32'(bus.gnt & ~bus.req), 32'(0));
      check("no_write_when_full", 32'(bus.fifo_wr_en && bus.fifo_full), 32'(0));
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i]) waitc[i] = 0;
        else if (bus.gnt[i]) begin
          check("grant_latency", 32'(waitc[i] + 1 <= WAIT_LIMIT), 32'(1));
          waitc[i] = 0;
        end else if (!bus.fifo_full) waitc[i]++;
      end
    end
  end

  initial begin
    int w;
    logic [N-1:0] rs;
    logic [N-1:0] order [10];
    rst_n = 1'b0;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) pdata[i] = DW'(8'hA0 + i);
    for (int i = 0; i < N; i++) waitc[i] = 0;
    model_reset();
    @(posedge clk);
    #1;

    // All producers requesting: pairs in round-robin order.
    apply_reset();
    order = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
              4'b1000, 4'b1000, 4'b0001, 4'b0001};
    for (int c = 0; c < 10; c++) drive_cycle('1, 1'b0, 1'b1, order[c], w);

    // Lone requester keeps being regranted.
    apply_reset();
    for (int c = 0; c < 5; c++) drive_cycle(4'b0100, 1'b0, 1'b1, 4'b0100, w);

    // Backpressure in the middle of a burst.
    apply_reset();
    drive_cycle(4'b0010, 1'b0, 1'b1, 4'b0010, w);
    for (int c = 0; c < 3; c++) drive_cycle(4'b0110, 1'b1, 1'b1, 4'b0000, w);
    drive_cycle(4'b0110, 1'b0, 1'b1, 4'b0010, w);
    drive_cycle(4'b0110, 1'b0, 1'b1, 4'b0100, w);

    // Expired burst, rotation past the owner, then a fresh burst for producer 1.
    apply_reset();
    drive_cycle(4'b0010, 1'b0, 1'b1, 4'b0010, w);
    drive_cycle(4'b0010, 1'b0, 1'b1, 4'b0010, w);
    drive_cycle(4'b1010, 1'b0, 1'b1, 4'b1000, w);
    drive_cycle(4'b0010, 1'b0, 1'b1, 4'b0010, w);
    drive_cycle(4'b0011, 1'b0, 1'b1, 4'b0010, w);

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    drive_cycle('1, 1'b0, 1'b1, 4'b0001, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt",   32'(bus.gnt), 32'(0));
    check("async_rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    check("async_rst_wdata", 32'(bus.fifo_wdata), 32'(0));
    check("async_rst_owner", 32'(bus.owner), 32'(N - 1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_cycle('1, 1'b0, 1'b1, 4'b0001, w);
    drive_cycle('1, 1'b0, 1'b1, 4'b0001, w);
    drive_cycle('1, 1'b0, 1'b1, 4'b0010, w);

    // Random producers that hold req and data until granted, random full.
    apply_reset();
    rs = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rs[i] && ($urandom % 3 == 0)) begin
          rs[i]    = 1'b1;
          pdata[i] = DW'($urandom);
        end
      end
      drive_cycle(rs, ($urandom % 4 == 0), 1'b0, '0, w);
      if (w >= 0) begin
        pdata[w] = DW'($urandom);
        rs[w]    = $urandom % 2;
      end
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
